// File: rtl/robs_mult_arbiter.sv
// Round-robin arbiter that shares one signed 8x8 Robertson multiplier between two requesters.
// state | meaning: IDLE wait for req | LOAD pulse mult_start | RUN wait done/timeout | RESP ack or err
module robs_mult_arbiter #(
    parameter int TIMEOUT = 32,
    parameter int CW      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [7:0]  a0,
    input  logic [7:0]  b0,
    input  logic        req1,
    input  logic [7:0]  a1,
    input  logic [7:0]  b1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [15:0] result,
    output logic        busy,
    output logic        mult_start,
    output logic [7:0]  mult_a,
    output logic [7:0]  mult_b,
    input  logic [15:0] mult_product,
    input  logic        mult_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [CW-1:0] LP_TC = CW'(TIMEOUT - 1);

    logic [1:0]    r_state;
    logic          r_last;
    logic          r_gnt;
    logic          r_prev_resp;
    logic          r_timeout;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_result;
    logic [7:0]    r_mult_a;
    logic [7:0]    r_mult_b;

    logic w_eff0;
    logic w_eff1;
    logic w_gnt_vld;
    logic w_gnt_id;

    // The requester just served may still hold req in the first IDLE cycle; ignore it there.
    assign w_eff0    = req0 & ~(r_prev_resp & ~r_gnt);
    assign w_eff1    = req1 & ~(r_prev_resp & r_gnt);
    assign w_gnt_vld = w_eff0 | w_eff1;
    assign w_gnt_id  = (w_eff0 & w_eff1) ? ~r_last : w_eff1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_gnt       <= 1'b0;
            r_prev_resp <= 1'b0;
            r_timeout   <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_mult_a    <= '0;
            r_mult_b    <= '0;
        end else begin
            r_prev_resp <= (r_state == S_RESP);
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_gnt    <= w_gnt_id;
                        r_last   <= w_gnt_id;
                        r_mult_a <= w_gnt_id ? a1 : a0;
                        r_mult_b <= w_gnt_id ? b1 : b0;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cnt     <= '0;
                    r_timeout <= 1'b0;
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    // done is checked first so a completion on the timeout cycle still succeeds
                    if (mult_done) begin
                        r_result  <= mult_product;
                        r_timeout <= 1'b0;
                        r_state   <= S_RESP;
                    end else if (r_cnt == LP_TC) begin
                        r_result  <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign mult_start = (r_state == S_LOAD);
    assign ack0       = (r_state == S_RESP) & ~r_timeout & ~r_gnt;
    assign ack1       = (r_state == S_RESP) & ~r_timeout & r_gnt;
    assign err0       = (r_state == S_RESP) & r_timeout & ~r_gnt;
    assign err1       = (r_state == S_RESP) & r_timeout & r_gnt;
    assign result     = r_result;
    assign mult_a     = r_mult_a;
    assign mult_b     = r_mult_b;

endmodule

// File: tb/tb_robs_mult_arbiter.sv
// Bench for robs_mult_arbiter: directed cases plus randomized traffic against a
// transaction-level timing/scoreboard model and a behavioural multiplier with variable latency.
module tb_robs_mult_arbiter;

    localparam int TIMEOUT = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        tb_req [2];
    logic [7:0]  tb_a [2];
    logic [7:0]  tb_b [2];
    logic        ack0, ack1, err0, err1, busy, mult_start, mult_done;
    logic [15:0] result, mult_product;
    logic [7:0]  mult_a, mult_b;

    robs_mult_arbiter #(.TIMEOUT(TIMEOUT), .CW(8)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .req0         (tb_req[0]),
        .a0           (tb_a[0]),
        .b0           (tb_b[0]),
        .req1         (tb_req[1]),
        .a1           (tb_a[1]),
        .b1           (tb_b[1]),
        .ack0         (ack0),
        .ack1         (ack1),
        .err0         (err0),
        .err1         (err1),
        .result       (result),
        .busy         (busy),
        .mult_start   (mult_start),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_product (mult_product),
        .mult_done    (mult_done)
    );

    function automatic logic [15:0] smul(logic [7:0] a, logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    // Multiplier: done is high exactly lat_cur cycles after start; lat_cur==0 never completes.
    int          lat_cur;
    int          m_rem;
    logic [15:0] m_prod, m_junk;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_prod <= '0;
            m_junk <= '0;
        end else begin
            m_junk <= 16'($urandom);
            if (mult_start) begin
                m_rem  <= lat_cur;
                m_prod <= smul(mult_a, mult_b);
            end else if (m_rem > 0) begin
                m_rem <= m_rem - 1;
            end
        end
    end
    assign mult_done    = (m_rem == 1);
    assign mult_product = mult_done ? m_prod : m_junk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int          cyc = 0;
    int          ptr, free_at, mask_cyc, mask_id;
    bit          in_flight;
    int          exp_start, exp_resp, exp_id;
    bit          exp_err;
    logic [15:0] exp_res;
    logic [7:0]  exp_a, exp_b;
    int          resp_count = 0;
    int          lat_next = 3;
    bit          rand_lat = 0;
    bit          rand_mode = 0;

    // Observed DUT activity
    int          obs_start, obs_resp, obs_id, start_pulses;
    bit          obs_err;
    logic [15:0] obs_res;

    bit sticky [2];
    bit late [2];
    int drop_cnt [2];

    task automatic model_reset();
        in_flight = 0;
        ptr       = 1;
        free_at   = cyc;
        mask_cyc  = -1;
        mask_id   = 0;
    endtask

    task automatic decide();
        bit e0, e1;
        int w, r;
        if (!in_flight && cyc >= free_at) begin
            e0 = tb_req[0] && !(mask_cyc == cyc && mask_id == 0);
            e1 = tb_req[1] && !(mask_cyc == cyc && mask_id == 1);
            if (e0 || e1) begin
                w   = (e0 && e1) ? (ptr == 0 ? 1 : 0) : (e0 ? 0 : 1);
                ptr = w;
                if (rand_lat) begin
                    r = $urandom_range(0, 19);
                    case (r)
                        15:      lat_cur = TIMEOUT;
                        16:      lat_cur = TIMEOUT + 1;
                        17:      lat_cur = 0;
                        18:      lat_cur = TIMEOUT - 1;
                        19:      lat_cur = 1;
                        default: lat_cur = 1 + $urandom_range(0, 7);
                    endcase
                end else begin
                    lat_cur = lat_next;
                end
                in_flight = 1;
                exp_id    = w;
                exp_start = cyc + 1;
                exp_a     = tb_a[w];
                exp_b     = tb_b[w];
                if (lat_cur >= 1 && lat_cur <= TIMEOUT) begin
                    exp_resp = cyc + 2 + lat_cur;
                    exp_err  = 0;
                    exp_res  = smul(tb_a[w], tb_b[w]);
                end else begin
                    exp_resp = cyc + TIMEOUT + 2;
                    exp_err  = 1;
                    exp_res  = '0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        bit start_e, busy_e, resp_e;
        start_e = in_flight && cyc == exp_start;
        busy_e  = in_flight && cyc >= exp_start;
        resp_e  = in_flight && cyc == exp_resp;
        check_eq("ctl", 32'({ack0, ack1, err0, err1, mult_start, busy}),
                 32'({resp_e && !exp_err && exp_id == 0, resp_e && !exp_err && exp_id == 1,
                      resp_e && exp_err && exp_id == 0, resp_e && exp_err && exp_id == 1,
                      start_e, busy_e}));
        if (mult_start) begin
            start_pulses++;
            obs_start = cyc;
        end
        if (start_e) check_eq("operands", 32'({mult_a, mult_b}), 32'({exp_a, exp_b}));
        if (ack0 | ack1 | err0 | err1) begin
            obs_resp = cyc;
            obs_res  = result;
            obs_err  = err0 | err1;
            obs_id   = (ack1 | err1) ? 1 : 0;
        end
        if (resp_e) begin
            check_eq("result", 32'(result), 32'(exp_res));
            in_flight = 0;
            free_at   = cyc + 1;
            mask_cyc  = cyc + 1;
            mask_id   = exp_id;
            resp_count++;
        end
    endtask

    task automatic requesters();
        bit got;
        for (int i = 0; i < 2; i++) begin
            if (drop_cnt[i] > 0) begin
                drop_cnt[i]--;
                if (drop_cnt[i] == 0) tb_req[i] = 1'b0;
            end
            got = (i == 0) ? (ack0 | err0) : (ack1 | err1);
            if (tb_req[i] && got && !sticky[i]) begin
                if (late[i]) drop_cnt[i] = 2;
                else         tb_req[i]   = 1'b0;
            end
            if (rand_mode && !tb_req[i] && drop_cnt[i] == 0 && $urandom_range(0, 3) == 0) begin
                tb_req[i] = 1'b1;
                tb_a[i]   = 8'($urandom);
                tb_b[i]   = 8'($urandom);
                late[i]   = bit'($urandom_range(0, 1));
            end else if (rand_mode && tb_req[i] && $urandom_range(0, 7) == 0) begin
                tb_a[i] = 8'($urandom);
            end
        end
    endtask

    task automatic cycle();
        decide();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
        requesters();
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic wait_resp(int maxc);
        int target;
        int k;
        target = resp_count + 1;
        k = 0;
        while (resp_count < target && k < maxc) begin
            cycle();
            k++;
        end
        if (resp_count < target) check_eq("wait_bound", 32'(resp_count), 32'(target));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ids [4];
        int k;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tb_req[i] = 1'b0; tb_a[i] = '0; tb_b[i] = '0;
            sticky[i] = 0; late[i] = 0; drop_cnt[i] = 0;
        end
        lat_cur = 3;
        start_pulses = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_ctl", 32'({ack0, ack1, err0, err1, busy, mult_start}), 32'(0));
        check_eq("reset_data", {result, mult_a, mult_b}, 32'(0));
        rst_n = 1'b1;
        model_reset();

        // Simultaneous requests straight after reset: requester 0 first
        tb_a[0] = 8'd127;  tb_b[0] = 8'h80;
        tb_a[1] = 8'h80;   tb_b[1] = 8'h80;
        tb_req[0] = 1'b1;  tb_req[1] = 1'b1;
        lat_next = 4;
        start_pulses = 0;
        wait_resp(60);
        check_eq("t2_first_id", 32'(obs_id), 32'(0));
        check_eq("t2_first_res", 32'(obs_res), 32'h0000_C080);
        wait_resp(60);
        check_eq("t2_second_id", 32'(obs_id), 32'(1));
        check_eq("t2_second_res", 32'(obs_res), 32'h0000_4000);
        run(4);
        check_eq("t2_starts", 32'(start_pulses), 32'(2));

        // Both held continuously: grants alternate
        sticky[0] = 1; sticky[1] = 1;
        tb_a[0] = 8'd6; tb_b[0] = 8'd7; tb_a[1] = 8'hF9; tb_b[1] = 8'd3;
        tb_req[0] = 1'b1; tb_req[1] = 1'b1;
        lat_next = 2;
        for (int i = 0; i < 4; i++) begin
            wait_resp(60);
            ids[i] = obs_id;
        end
        tb_req[0] = 1'b0; tb_req[1] = 1'b0;
        sticky[0] = 0; sticky[1] = 0;
        for (int i = 0; i < 4; i++) check_eq($sformatf("t3_grant%0d", i), 32'(ids[i]), 32'(i % 2));
        run(3);

        // Single requester, -3 * 5
        tb_a[0] = 8'hFD; tb_b[0] = 8'h05; tb_req[0] = 1'b1;
        lat_next = 3;
        start_pulses = 0;
        wait_resp(60);
        check_eq("t1_id", 32'(obs_id), 32'(0));
        check_eq("t1_res", 32'(obs_res), 32'h0000_FFF1);
        check_eq("t1_latency", 32'(obs_resp - obs_start), 32'(4));
        run(3);
        check_eq("t1_starts", 32'(start_pulses), 32'(1));

        // Operand change after grant is ignored
        tb_a[0] = 8'd2; tb_b[0] = 8'd3; tb_req[0] = 1'b1;
        cycle();
        cycle();
        tb_a[0] = 8'd9;
        wait_resp(60);
        check_eq("t6_res", 32'(obs_res), 32'h0000_0006);
        run(3);

        // Multiplier never completes: timeout error
        tb_a[0] = 8'd5; tb_b[0] = 8'd7; tb_req[0] = 1'b1;
        lat_next = 0;
        wait_resp(80);
        check_eq("t4_err", 32'(obs_err), 32'(1));
        check_eq("t4_res", 32'(obs_res), 32'(0));
        check_eq("t4_gap", 32'(obs_resp - obs_start), 32'(33));
        run(2);
        tb_a[0] = 8'hF0; tb_b[0] = 8'd3; tb_req[0] = 1'b1;
        lat_next = 2;
        wait_resp(60);
        check_eq("t4_next_err", 32'(obs_err), 32'(0));
        check_eq("t4_next_res", 32'(obs_res), 32'h0000_FFD0);
        run(2);

        // Done on the last allowed cycle wins over timeout
        tb_a[1] = 8'd3; tb_b[1] = 8'd4; tb_req[1] = 1'b1;
        lat_next = TIMEOUT;
        wait_resp(80);
        check_eq("edge_done_err", 32'(obs_err), 32'(0));
        check_eq("edge_done_res", 32'(obs_res), 32'h0000_000C);
        run(2);

        // Reset during RUN with req1 pending
        sticky[1] = 1;
        tb_a[1] = 8'd11; tb_b[1] = 8'd13; tb_req[1] = 1'b1;
        lat_next = 0;
        run(6);
        rst_n = 1'b0;
        #1;
        check_eq("t5_ctl", 32'({ack0, ack1, err0, err1, busy, mult_start}), 32'(0));
        check_eq("t5_data", {result, mult_a, mult_b}, 32'(0));
        in_flight = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            check_eq("t5_hold", 32'({ack1, err1, busy, mult_start}), 32'(0));
        end
        tb_a[1] = 8'd12; tb_b[1] = 8'd10;
        sticky[1] = 0;
        lat_next = 5;
        rst_n = 1'b1;
        model_reset();
        wait_resp(60);
        check_eq("t5_id", 32'(obs_id), 32'(1));
        check_eq("t5_err", 32'(obs_err), 32'(0));
        check_eq("t5_res", 32'(obs_res), 32'h0000_0078);
        run(2);

        // One cycle past the limit: timeout
        tb_a[1] = 8'd3; tb_b[1] = 8'd4; tb_req[1] = 1'b1;
        lat_next = TIMEOUT + 1;
        wait_resp(80);
        check_eq("edge_late_err", 32'(obs_err), 32'(1));
        check_eq("edge_late_res", 32'(obs_res), 32'(0));
        run(2);

        // Randomized traffic
        rand_mode = 1;
        rand_lat  = 1;
        run(1500);
        rand_mode = 0;
        k = 0;
        while ((in_flight || tb_req[0] || tb_req[1]) && k < 300) begin
            cycle();
            k++;
        end
        if (in_flight || tb_req[0] || tb_req[1]) check_eq("drain_bound", 32'(k), 32'(0));
        run(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/robs_mult_arbiter.md
Name: robs_mult_arbiter

Overview:
- Shares one Robertson's signed 8x8 multiplier (8-bit multiplier/multiplicand in, 16-bit product and done out) between two requesters.
- Arbitrates round-robin, latches the winner's operands, and pulses the multiplier's start.
- Waits for done, with a cycle-count timeout, then returns the product to the winner with a one-cycle ack.
- Sits between the lab's top-level multiplier and the testbench/requester logic.

Parameters:
- TIMEOUT, 32, maximum cycles to wait in RUN for mult_done before aborting; legal range 2..255.
- CW, 8, width of the internal wait counter; must hold TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; this polarity and synchronicity are fixed.
- req0  input  1  requester 0 request; held high until ack0 or err0.
- a0  input  8  requester 0 multiplier, signed.
- b0  input  8  requester 0 multiplicand, signed.
- req1  input  1  requester 1 request.
- a1  input  8  requester 1 multiplier, signed.
- b1  input  8  requester 1 multiplicand, signed.
- ack0  output  1  one-cycle pulse: result valid for requester 0.
- ack1  output  1  one-cycle pulse: result valid for requester 1.
- err0  output  1  one-cycle pulse: requester 0 timed out.
- err1  output  1  one-cycle pulse: requester 1 timed out.
- result  output  16  product, valid while ack0 or ack1 is high.
- busy  output  1  high in any state other than IDLE.
- mult_start  output  1  one-cycle start pulse to the multiplier (drives its local reset/start input).
- mult_a  output  8  latched multiplier operand.
- mult_b  output  8  latched multiplicand operand.
- mult_product  input  16  multiplier product.
- mult_done  input  1  multiplier completion flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE, last-grant pointer=1, so requester 0 wins the first tie.
  - All outputs 0: ack*, err*, result, busy, mult_start, mult_a, mult_b; counter 0.
- States: IDLE -> LOAD -> RUN -> RESP -> IDLE.
- IDLE:
  - No request: stay.
  - Exactly one req high: grant it.
  - Both high: grant the requester not equal to the last-grant pointer, then update the pointer to the winner.
  - On grant, latch a/b of the winner into mult_a/mult_b and the grant ID; go to LOAD.
- LOAD:
  - mult_start=1 for exactly this cycle; counter cleared; go to RUN.
- RUN:
  - mult_start=0; counter increments each cycle.
  - mult_done=1 (sampled from the cycle after LOAD onward): latch mult_product into result; go to RESP.
  - mult_done=0 when counter reaches TIMEOUT-1: result=0, flag timeout; go to RESP.
  - mult_done in the same cycle as the timeout: done wins, no error.
- RESP:
  - ack of the granted requester=1 for one cycle, or err of the granted requester on timeout.
  - result holds its value until the next RESP and is otherwise don't-care to requesters.
  - Go to IDLE.
- Latency: single requester from IDLE, req high at cycle 0 -> mult_start at cycle 1 -> ack at N+2, where the multiplier asserts done N cycles after start.
- IDLE ignores a requester's req in the cycle immediately after its ack/err, so a dropped req is not regranted.
- Operands are captured only at grant; a0/b0/a1/b1 changes afterwards have no effect.
- busy=1 in LOAD, RUN and RESP.
- A req dropped mid-operation does not abort; ack is still issued.
- reset asserted in any state aborts immediately to IDLE with all outputs cleared; no ack or err is issued for the aborted transaction.
- Arithmetic: no modification of the product; all 16 bits of mult_product pass through unchanged (signed).

Test Plan:
- req0 only, a0=-3 (8'hFD), b0=5 -> one mult_start pulse, mult_a=8'hFD, mult_b=8'h05; ack0 one cycle with result=16'hFFF1; ack1=0.
- req0 and req1 both rise in the same cycle after reset, (127,-128) and (-128,-128):
  - Requester 0 served first, result=16'hC080.
  - Then requester 1, result=16'h4000.
  - Exactly two mult_start pulses.
- Both held continuously for 4 transactions -> grants alternate 0,1,0,1; no back-to-back grant to the same requester.
- Multiplier model never asserts done, TIMEOUT=32 -> err0 pulses 33 cycles after mult_start, result=0, ack0 never high; next request serviced normally.
- Reset pulled low while in RUN with req1 pending -> all outputs 0 asynchronously; no ack1 or err1. After release, req1 (12,10) -> ack1 with result=16'h0078.
- Change a0 from 2 to 9 one cycle after grant, b0=3 -> result=16'h0006.
